branch_target_buffer: RTL and testbench

- Fetch-side prediction stage, directly upstream of the conditional-branch controller; supplies `pred_taken` and `pred_pc` for the instruction being fetched.
- Direct-mapped table of tag, target and 2-bit saturating counter, indexed by fetch PC.
- Trained by the resolved-branch update port from execute, so predictions improve over time.

---
 rtl/branch_target_buffer_if.sv | 50 +++++
 rtl/branch_target_buffer.sv | 149 ++++++++++++++
 tb/tb_branch_target_buffer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/branch_target_buffer_if.sv
// Fetch/update bus for branch_target_buffer. With BTB_STATS_EN defined the
// statistics counters are carried here as well.
interface branch_target_buffer_if #(
  parameter int WordSize = 32
) ();

  logic [WordSize-1:0] fetch_pc;
  logic                pred_taken;
  logic [WordSize-1:0] pred_pc;
  logic                pred_hit;
  logic                upd_valid;
  logic [WordSize-1:0] upd_pc;
  logic [WordSize-1:0] upd_target;
  logic                upd_taken;
`ifdef BTB_STATS_EN
  logic [31:0]         stat_lookups;
  logic [31:0]         stat_mispred;
`endif

  modport master (
    output fetch_pc,
    output upd_valid,
    output upd_pc,
    output upd_target,
    output upd_taken,
`ifdef BTB_STATS_EN
    input  stat_lookups,
    input  stat_mispred,
`endif
    input  pred_taken,
    input  pred_pc,
    input  pred_hit
  );

  modport slave (
    input  fetch_pc,
    input  upd_valid,
    input  upd_pc,
    input  upd_target,
    input  upd_taken,
`ifdef BTB_STATS_EN
    output stat_lookups,
    output stat_mispred,
`endif
    output pred_taken,
    output pred_pc,
    output pred_hit
  );

endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Optional feature macro BTB_STATS_EN adds lookup/mispredict counters.
module branch_target_buffer #(
  parameter int WordSize = 32,
  parameter int Entries  = 16
) (
  input  logic                  clk,
  input  logic                  rstn_h,
  branch_target_buffer_if.slave bus
);

  localparam int IdxBits = $clog2(Entries);
  localparam int TagBits = WordSize - IdxBits - 2;

  // Saturating counter step: never wraps past 2'b11 or below 2'b00.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
    logic [1:0] res;
    if (up) begin
      if (ctr != 2'b11) res = ctr + 2'b01;
      else              res = ctr;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'b01;
      else              res = ctr;
    end
    return res;
  endfunction

  logic                r_valid  [Entries];
  logic [TagBits-1:0]  r_tag    [Entries];
  logic [WordSize-1:0] r_target [Entries];
  logic [1:0]          r_ctr    [Entries];

  logic [IdxBits-1:0]  w_f_idx;
  logic [TagBits-1:0]  w_f_tag;
  logic                w_f_hit;
  logic                w_f_taken;
  logic [WordSize-1:0] w_f_seq;
  logic [WordSize-1:0] w_f_next;

  logic [IdxBits-1:0]  w_u_idx;
  logic [TagBits-1:0]  w_u_tag;
  logic                w_u_hit;
  logic                w_u_pred;
  logic [1:0]          w_ctr_nxt;
  logic                w_wr_en;
  logic                w_alloc;
  logic                w_tgt_en;
  logic                w_unused_ok;

  // Fetch-side lookup from registered table state, zero latency.
  always_comb begin
    w_f_idx   = bus.fetch_pc[IdxBits+1:2];
    w_f_tag   = bus.fetch_pc[WordSize-1:IdxBits+2];
    w_f_hit   = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    w_f_taken = w_f_hit && r_ctr[w_f_idx][1];
    w_f_seq   = bus.fetch_pc + WordSize'(4);
    if (w_f_taken) begin
      w_f_next = r_target[w_f_idx];
    end else begin
      w_f_next = w_f_seq;
    end
  end

  assign bus.pred_hit   = w_f_hit;
  assign bus.pred_taken = w_f_taken;
  assign bus.pred_pc    = w_f_next;

  // Low PC bits are word-offset only and never index the table.
  assign w_unused_ok = &{1'b0, bus.upd_pc[1:0]};

  // Update decode: hits train the counter, taken misses allocate.
  always_comb begin
    w_u_idx   = bus.upd_pc[IdxBits+1:2];
    w_u_tag   = bus.upd_pc[WordSize-1:IdxBits+2];
    w_u_hit   = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    w_u_pred  = w_u_hit && r_ctr[w_u_idx][1];
    w_ctr_nxt = r_ctr[w_u_idx];
    w_wr_en   = 1'b0;
    w_alloc   = 1'b0;
    w_tgt_en  = 1'b0;
    if (bus.upd_valid) begin
      if (w_u_hit) begin
        w_wr_en   = 1'b1;
        w_ctr_nxt = ctr_step(r_ctr[w_u_idx], bus.upd_taken);
        w_tgt_en  = bus.upd_taken;
      end else if (bus.upd_taken) begin
        w_wr_en   = 1'b1;
        w_alloc   = 1'b1;
        w_tgt_en  = 1'b1;
        w_ctr_nxt = 2'b10;
      end else begin
        w_wr_en   = 1'b0;
      end
    end else begin
      w_wr_en = 1'b0;
    end
  end

  // Table storage; reset wins over any update in the same cycle.
  always_ff @(posedge clk or posedge rstn_h) begin
    if (rstn_h) begin
      for (int i = 0; i < Entries; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (w_wr_en) begin
      r_ctr[w_u_idx] <= w_ctr_nxt;
      if (w_alloc) begin
        r_valid[w_u_idx] <= 1'b1;
        r_tag[w_u_idx]   <= w_u_tag;
      end
      if (w_tgt_en) begin
        r_target[w_u_idx] <= bus.upd_target;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] r_stat_lookups;
  logic [31:0] r_stat_mispred;
  logic        w_u_mispred;

  assign w_u_mispred = (w_u_pred != bus.upd_taken);

  // Statistics counters, saturating at all-ones.
  always_ff @(posedge clk or posedge rstn_h) begin
    if (rstn_h) begin
      r_stat_lookups <= 32'd0;
      r_stat_mispred <= 32'd0;
    end else if (bus.upd_valid) begin
      if (r_stat_lookups != 32'hFFFF_FFFF) begin
        r_stat_lookups <= r_stat_lookups + 32'd1;
      end
      if (w_u_mispred && (r_stat_mispred != 32'hFFFF_FFFF)) begin
        r_stat_mispred <= r_stat_mispred + 32'd1;
      end
    end
  end

  assign bus.stat_lookups = r_stat_lookups;
  assign bus.stat_mispred = r_stat_mispred;
`else
  logic w_unused_pred;
  assign w_unused_pred = w_u_pred;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (Entries=16).
module tb_branch_target_buffer;

  logic clk;
  logic rstn_h;
  int   n_assert;
  int   n_fail;

  branch_target_buffer_if #(.WordSize(32)) bus ();

  branch_target_buffer #(
    .WordSize(32),
    .Entries (16)
  ) dut (
    .clk   (clk),
    .rstn_h(rstn_h),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic hit, input logic tk, input logic [31:0] npc);
    bus.fetch_pc = pc;
    #1;
    chk({tag, "_hit"},   {31'd0, bus.pred_hit},   {31'd0, hit});
    chk({tag, "_taken"}, {31'd0, bus.pred_taken}, {31'd0, tk});
    chk({tag, "_pc"},    bus.pred_pc,             npc);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    bus.upd_pc     = pc;
    bus.upd_target = tgt;
    bus.upd_taken  = tk;
    bus.upd_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.upd_valid  = 1'b0;
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    rstn_h         = 1'b1;
    bus.fetch_pc   = 32'h0000_0100;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = 32'h0;
    bus.upd_target = 32'h0;
    bus.upd_taken  = 1'b0;
    look("reset", 32'h0000_0100, 1'b0, 1'b0, 32'h0000_0104);
    rstn_h = 1'b0;
    @(posedge clk);
    #1;

    // Allocate on taken miss, counter starts weakly taken.
    upd(32'h100, 32'h200, 1'b1);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

    // Walk the counter down to 00, including one saturating step.
    upd(32'h100, 32'h0, 1'b0);
    look("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 32'h0, 1'b0);
    upd(32'h100, 32'h0, 1'b0);
    upd(32'h100, 32'h200, 1'b1);
    look("sat00_t1", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 32'h200, 1'b1);
    look("t2", 32'h100, 1'b1, 1'b1, 32'h200);

    // Saturate at 11: one not-taken afterwards must still predict taken.
    for (int i = 0; i < 4; i++) upd(32'h100, 32'h200, 1'b1);
    upd(32'h100, 32'h0, 1'b0);
    look("sat11_nt1", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 32'h0, 1'b0);
    look("sat11_nt2", 32'h100, 1'b1, 1'b0, 32'h104);

    // Taken hits refresh the target, not-taken hits leave it alone.
    upd(32'h100, 32'h250, 1'b1);
    look("retarget", 32'h100, 1'b1, 1'b1, 32'h250);
    upd(32'h100, 32'h250, 1'b1);
    upd(32'h100, 32'h999, 1'b0);
    look("nt_keep_tgt", 32'h100, 1'b1, 1'b1, 32'h250);

    // Aliasing on index 0 and no allocation for not-taken miss.
    upd(32'h140, 32'h300, 1'b1);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("alias_new", 32'h140, 1'b1, 1'b1, 32'h300);
    look("low_bits", 32'h142, 1'b1, 1'b1, 32'h300);
    upd(32'h180, 32'h500, 1'b0);
    look("nt_miss", 32'h180, 1'b0, 1'b0, 32'h184);
    look("nt_miss_keep", 32'h140, 1'b1, 1'b1, 32'h300);

    // Table holds when the strobe is low.
    bus.upd_pc     = 32'h100;
    bus.upd_target = 32'h777;
    bus.upd_taken  = 1'b1;
    @(posedge clk);
    #1;
    look("hold", 32'h100, 1'b0, 1'b0, 32'h104);

    // Same-cycle lookup and update: old contents now, new next cycle.
    bus.fetch_pc   = 32'h100;
    bus.upd_pc     = 32'h100;
    bus.upd_target = 32'h400;
    bus.upd_taken  = 1'b1;
    bus.upd_valid  = 1'b1;
    look("same_old", 32'h100, 1'b0, 1'b0, 32'h104);
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    look("same_new", 32'h100, 1'b1, 1'b1, 32'h400);

    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

    // Reset mid-operation clears immediately and masks a concurrent update.
    bus.upd_pc     = 32'h140;
    bus.upd_target = 32'h600;
    bus.upd_taken  = 1'b1;
    bus.upd_valid  = 1'b1;
    rstn_h         = 1'b1;
    look("midrst", 32'h100, 1'b0, 1'b0, 32'h104);
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    rstn_h        = 1'b0;
    look("midrst_upd", 32'h140, 1'b0, 1'b0, 32'h144);
    look("midrst_old", 32'h100, 1'b0, 1'b0, 32'h104);

`ifdef BTB_STATS_EN
    chk("stat_lk_rst", bus.stat_lookups, 32'd0);
    chk("stat_mp_rst", bus.stat_mispred, 32'd0);
    upd(32'h100, 32'h200, 1'b1);
    upd(32'h100, 32'h200, 1'b1);
    upd(32'h100, 32'h0,   1'b0);
    upd(32'h180, 32'h0,   1'b0);
    upd(32'h100, 32'h200, 1'b1);
    chk("stat_lk", bus.stat_lookups, 32'd5);
    chk("stat_mp", bus.stat_mispred, 32'd2);
    rstn_h = 1'b1;
    #1;
    chk("stat_lk_clr", bus.stat_lookups, 32'd0);
    chk("stat_mp_clr", bus.stat_mispred, 32'd0);
    rstn_h = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
